cache_ctrl: RTL

Direct-mapped, write-back, write-allocate cache controller between the CPU load/store port and `dataMemory`. It holds 16 lines of four 32-bit words, answers hits from its own storage, and sequences `dataMemory` on misses: a four-beat word writeback of a dirty victim, then a single-cycle 128-bit line fetch. It sits in the memory stage; the CPU stalls on `cpu_ready` low.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_line_array.sv | 69 ++++++
 rtl/cache_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types, geometry and line-bus helpers for the direct-mapped cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } cacheState_e;

  localparam int OFFSET_W       = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;

  localparam int DEFAULT_LINES  = 16;
  localparam int DEFAULT_ADDR_W = 10;
  localparam int INDEX_W        = $clog2(DEFAULT_LINES);
  localparam int TAG_W          = DEFAULT_ADDR_W - INDEX_W - OFFSET_W;

  // Word k of a line sits at the high end of the bus for k = 0.
  function automatic logic [WORD_W-1:0] lineWord(input logic [LINE_W-1:0] line,
                                                 input logic [OFFSET_W-1:0] k);
    return line[(WORDS_PER_LINE - 1 - int'(k)) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage: one combinational read port and one write port
// that either updates a single word or fills a whole line.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int LINES    = DEFAULT_LINES,
  parameter int IDX_BITS = $clog2(LINES),
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rdIndex,
  output logic                rdValid,
  output logic                rdDirty,
  output logic [TAG_BITS-1:0] rdTag,
  output logic [LINE_W-1:0]   rdLine,
  input  logic [IDX_BITS-1:0] wrIndex,
  input  logic                wordWe,
  input  logic [OFFSET_W-1:0] wrOffset,
  input  logic [WORD_W-1:0]   wrData,
  input  logic                fillEn,
  input  logic [TAG_BITS-1:0] fillTag,
  input  logic [LINE_W-1:0]   fillLine
);

  logic [LINES-1:0]    validBits;
  logic [LINES-1:0]    dirtyBits;
  logic [TAG_BITS-1:0] tagMem [LINES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (fillEn) begin
      validBits[wrIndex] <= 1'b1;
      dirtyBits[wrIndex] <= 1'b0;
    end else if (wordWe) begin
      dirtyBits[wrIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagMem[wrIndex] <= fillTag;
    end
  end

  // One storage array per word column keeps each array single-writer.
  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : gWord
      logic [WORD_W-1:0] wordMem [LINES];

      always_ff @(posedge clk) begin
        if (fillEn) begin
          wordMem[wrIndex] <= lineWord(fillLine, OFFSET_W'(gi));
        end else if (wordWe && (wrOffset == OFFSET_W'(gi))) begin
          wordMem[wrIndex] <= wrData;
        end
      end

      assign rdLine[(WORDS_PER_LINE - 1 - gi) * WORD_W +: WORD_W] = wordMem[rdIndex];
    end
  endgenerate

  assign rdValid = validBits[rdIndex];
  assign rdDirty = dirtyBits[rdIndex];
  assign rdTag   = tagMem[rdIndex];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: request latch, miss
// sequencing FSM (word writeback of a dirty victim, then a one-cycle line fill).
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES  = DEFAULT_LINES,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFFSET_W;

  cacheState_e         stateReg;
  logic [OFFSET_W-1:0] beatReg;
  logic                reqWe;
  logic [OFFSET_W-1:0] reqOffset;
  logic [IDX_BITS-1:0] reqIndex;
  logic [TAG_BITS-1:0] reqTag;
  logic [WORD_W-1:0]   reqWdata;
  logic                cpuReadyReg;
  logic [WORD_W-1:0]   cpuRdataReg;

  logic                lineValid;
  logic                lineDirty;
  logic [TAG_BITS-1:0] lineTag;
  logic [LINE_W-1:0]   lineData;
  logic                hit;
  logic                wordWe;
  logic                fillEn;
  logic                unusedAddrBits;

  assign unusedAddrBits = ^cpu_addr[31:ADDR_W];

  cache_line_array #(
    .LINES    (LINES),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) uLines (
    .clk      (clk),
    .reset    (reset),
    .rdIndex  (reqIndex),
    .rdValid  (lineValid),
    .rdDirty  (lineDirty),
    .rdTag    (lineTag),
    .rdLine   (lineData),
    .wrIndex  (reqIndex),
    .wordWe   (wordWe),
    .wrOffset (reqOffset),
    .wrData   (reqWdata),
    .fillEn   (fillEn),
    .fillTag  (reqTag),
    .fillLine (mem_rdata)
  );

  assign hit    = lineValid && (lineTag == reqTag);
  assign wordWe = (stateReg == COMPARE) && hit && reqWe;
  assign fillEn = (stateReg == ALLOCATE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      beatReg     <= '0;
      reqWe       <= 1'b0;
      reqOffset   <= '0;
      reqIndex    <= '0;
      reqTag      <= '0;
      reqWdata    <= '0;
      cpuReadyReg <= 1'b0;
      cpuRdataReg <= '0;
    end else begin
      cpuReadyReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          // A request still held during its own completion cycle is not re-accepted.
          if (cpu_req && !cpuReadyReg) begin
            reqWe     <= cpu_we;
            reqOffset <= cpu_addr[OFFSET_W-1:0];
            reqIndex  <= cpu_addr[OFFSET_W +: IDX_BITS];
            reqTag    <= cpu_addr[OFFSET_W + IDX_BITS +: TAG_BITS];
            reqWdata  <= cpu_wdata;
            stateReg  <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (!reqWe) begin
              cpuRdataReg <= lineWord(lineData, reqOffset);
            end
            cpuReadyReg <= 1'b1;
            stateReg    <= IDLE;
          end else if (lineValid && lineDirty) begin
            beatReg  <= '0;
            stateReg <= WRITEBACK;
          end else begin
            stateReg <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          beatReg <= beatReg + 1'b1;
          if (beatReg == OFFSET_W'(WORDS_PER_LINE - 1)) begin
            stateReg <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          stateReg <= COMPARE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Memory-side outputs depend only on registered state, so they hold across the negedge.
  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (stateReg)
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = 32'({lineTag, reqIndex, beatReg});
        mem_wdata = lineWord(lineData, beatReg);
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = 32'({reqTag, reqIndex, {OFFSET_W{1'b0}}});
      end
      default: ;
    endcase
  end

  assign cpu_ready = cpuReadyReg;
  assign cpu_rdata = cpuRdataReg;

endmodule
